// File: rtl/lut4_chk_pkg.sv
// Shared types and constants for the LUT4 sweep checker.
`timescale 1ns/1ps
package lut4_chk_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  // Expected response of the LUT-under-test in the default feature design.
  localparam logic [15:0] DEFAULT_TRUTH_TABLE = 16'hFF5F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/lut4_chk_sync.sv
// Two-flop synchronizer for the LUT-under-test output, which is not timed
// against clk. Both flops reset to 0.
`timescale 1ns/1ps
module lut4_chk_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lut4_sweep_checker.sv
// On-chip sweep tester for one 4-input LUT: drives all 16 input vectors,
// waits SETTLE_CYCLES per vector, samples the synchronized LUT output and
// tallies mismatches against TRUTH_TABLE.
// Optional macro LUT4_SWEEP_FAIL_MASK_EN adds a per-vector fail_mask output.
//
// Control protocol: start is a single-cycle request that is accepted only
// while the FSM is in IDLE (busy low and no DONE cycle in progress); busy
// rises the cycle after an accepted start and falls together with the
// one-cycle done pulse; results are stable from done until the next
// accepted start.
`timescale 1ns/1ps
module lut4_sweep_checker
  import lut4_chk_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE   = DEFAULT_TRUTH_TABLE,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] lut_i,
  input  logic             lut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
`ifdef LUT4_SWEEP_FAIL_MASK_EN
  output logic [15:0]      fail_mask,
`endif
  output state_t           state_dbg
);

  // The synchronizer needs two settle cycles to fill; the counter must hold
  // SETTLE_CYCLES-1.
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > (1 << CNT_W)) begin : g_bad_settle
    $error("lut4_sweep_checker: SETTLE_CYCLES must be in 2..%0d", 1 << CNT_W);
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             lut_sync;
  logic             mismatch;

  lut4_chk_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lut_o),
    .q     (lut_sync)
  );

  assign mismatch  = (lut_sync != TRUTH_TABLE[idx]);
  assign state_dbg = state;

  // Sweep FSM: DRIVE -> SETTLE x SETTLE_CYCLES -> SAMPLE per vector, then DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      lut_i          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
`ifdef LUT4_SWEEP_FAIL_MASK_EN
      fail_mask      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fail_count     <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            idx            <= '0;
            busy           <= 1'b1;
`ifdef LUT4_SWEEP_FAIL_MASK_EN
            fail_mask      <= '0;
`endif
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          lut_i <= idx;
          cnt   <= CNT_W'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            // At most 16 mismatches, so 5 bits never wrap.
            fail_count <= fail_count + 5'd1;
            if (fail_count == '0) begin
              first_fail_idx <= idx;
            end
`ifdef LUT4_SWEEP_FAIL_MASK_EN
            fail_mask[idx] <= 1'b1;
`endif
          end
          if (idx == '1) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (fail_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut4_sweep_checker.sv
// Bench for lut4_sweep_checker: table of sweep scenarios (LUT model contents
// plus expected results) followed by hand-written start/reset corner cases.
// Expected lut_i vectors go into exp_q when a sweep starts and are popped
// each time the checker samples a vector.
`timescale 1ns/1ps
module tb_lut4_sweep_checker;
  import lut4_chk_pkg::*;

  localparam logic [15:0] TT         = 16'hFF5F;
  localparam int          SC         = 4;
  // Edge count from the edge that accepts start (counted as 1) to the edge
  // after which done is high.
  localparam int          DONE_EDGES = 16 * (SC + 2) + 2;

  typedef struct {
    logic [15:0] model_tt;
    int          mode;      // 0 plain, 1 re-start at vector 3, 2 start during DONE
    logic        exp_pass;
    logic [4:0]  exp_fc;
    logic [3:0]  exp_ffi;
    logic [15:0] exp_mask;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  lut_i;
  logic        lut_o;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;
`ifdef LUT4_SWEEP_FAIL_MASK_EN
  logic [15:0] fail_mask;
`endif
  state_t      state_dbg;

  logic [15:0] model_tt = TT;
  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          done_cnt = 0;
  vec_t        tbl[9];

  // ---------------- clock / reset / LUT model ----------------
  always #10 clk = ~clk;

  assign #10 lut_o = model_tt[lut_i];

  lut4_sweep_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(SC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .lut_i          (lut_i),
    .lut_o          (lut_o),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
`ifdef LUT4_SWEEP_FAIL_MASK_EN
    .fail_mask      (fail_mask),
`endif
    .state_dbg      (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (rst_n && state_dbg == SAMPLE) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL lut_i_extra: vector 0x%0h sampled with nothing expected", lut_i);
      end else begin
        check("lut_i_seq", {28'd0, lut_i}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input int id, input vec_t v);
    int n;
    int dc0;
    bit got;
    model_tt = v.model_tt;
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); n = 1; #1;
    check($sformatf("s%0d_busy_rise", id), {31'd0, busy}, 32'd1);
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    while (!got && n < DONE_EDGES + 20) begin
      @(posedge clk); n++; #1;
      if (v.mode == 1 && n == 20) start = 1'b1;
      if (v.mode == 1 && n == 21) start = 1'b0;
      if (v.mode == 2 && n == DONE_EDGES - 1) start = 1'b1;
      if (v.mode == 2 && n == DONE_EDGES) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check($sformatf("s%0d_done_latency", id), n, DONE_EDGES);
    check($sformatf("s%0d_busy_at_done", id), {31'd0, busy}, 32'd0);
    check($sformatf("s%0d_pass", id), {31'd0, pass}, {31'd0, v.exp_pass});
    check($sformatf("s%0d_fail_count", id), {27'd0, fail_count}, {27'd0, v.exp_fc});
    check($sformatf("s%0d_first_fail", id), {28'd0, first_fail_idx}, {28'd0, v.exp_ffi});
`ifdef LUT4_SWEEP_FAIL_MASK_EN
    check($sformatf("s%0d_fail_mask", id), {16'd0, fail_mask}, {16'd0, v.exp_mask});
`endif
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("s%0d_done_pulses", id), done_cnt - dc0, 1);
    check($sformatf("s%0d_idle_after", id), {29'd0, state_dbg}, {29'd0, IDLE});
    check($sformatf("s%0d_busy_after", id), {31'd0, busy}, 32'd0);
    check($sformatf("s%0d_fail_count_hold", id), {27'd0, fail_count}, {27'd0, v.exp_fc});
    check($sformatf("s%0d_vectors_left", id), exp_q.size(), 0);
  endtask

  function automatic vec_t fault_row(input logic [15:0] fault, input int mode);
    vec_t r;
    r.model_tt = TT ^ fault;
    r.mode     = mode;
    r.exp_pass = (fault == 16'd0);
    r.exp_fc   = 5'($countones(fault));
    r.exp_mask = fault;
    r.exp_ffi  = 4'd0;
    for (int b = 15; b >= 0; b--) if (fault[b]) r.exp_ffi = 4'(b);
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int dc0;
    tbl[0] = '{16'hFF5F, 0, 1'b1, 5'd0,  4'd0,  16'h0000};  // ideal LUT
    tbl[1] = '{16'hFF7F, 0, 1'b0, 5'd1,  4'd5,  16'h0020};  // bit 5 inverted
    tbl[2] = '{16'h0000, 0, 1'b0, 5'd14, 4'd0,  16'hFF5F};  // stuck at 0
    tbl[3] = '{16'hFFFF, 0, 1'b0, 5'd2,  4'd5,  16'h00A0};  // stuck at 1
    tbl[4] = '{16'hFF5F, 1, 1'b1, 5'd0,  4'd0,  16'h0000};  // re-start at vector 3
    tbl[5] = '{16'h7F5F, 2, 1'b0, 5'd1,  4'd15, 16'h8000};  // start during DONE
    for (int r = 6; r < 9; r++) tbl[r] = fault_row(16'($urandom_range(1, 16'hFFFF)), 0);

    // Reset state
    #25;
    check("rst_lut_i", {28'd0, lut_i}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fail_count", {27'd0, fail_count}, 32'd0);
    check("rst_first_fail", {28'd0, first_fail_idx}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, IDLE});
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 9; r++) run_sweep(r, tbl[r]);

    // Abort a sweep with reset while vector 7 is settling.
    model_tt = TT ^ 16'h0008;
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk); start = 1'b0;
    while (n < 45) begin @(posedge clk); n++; end
    #1;
    check("abort_pre_lut_i", {28'd0, lut_i}, 32'd7);
    check("abort_pre_fail_count", {27'd0, fail_count}, 32'd1);
    check("abort_pre_first_fail", {28'd0, first_fail_idx}, 32'd3);
    #2; rst_n = 1'b0; #1;
    check("abort_lut_i", {28'd0, lut_i}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_fail_count", {27'd0, fail_count}, 32'd0);
    check("abort_first_fail", {28'd0, first_fail_idx}, 32'd0);
    check("abort_state", {29'd0, state_dbg}, {29'd0, IDLE});
`ifdef LUT4_SWEEP_FAIL_MASK_EN
    check("abort_fail_mask", {16'd0, fail_mask}, 32'd0);
`endif
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_sweep(9, tbl[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
